// File: rtl/venus_pkg.sv
// Shared definitions for the venus pipeline: instruction layout, class codes,
// decoded control bundle and the decode hazard FSM states.
package venus_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned IW   = 16;

  typedef enum logic [2:0] {
    CLS_INTE  = 3'd0,
    CLS_LOGIC = 3'd1,
    CLS_SHIFT = 3'd2,
    CLS_LD    = 3'd3,
    CLS_ST    = 3'd4,
    CLS_BR    = 3'd5,
    CLS_ILL6  = 3'd6,
    CLS_ILL7  = 3'd7
  } cls_e;

  // Field layout, MSB first: [31:29] cls, [28] immf, [27:26] subop,
  // [25:21] rd, [20:16] rs, [15:0] imm.
  typedef struct packed {
    logic [2:0]    cls;
    logic          immf;
    logic [1:0]    subop;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [IW-1:0] imm;
  } inst_t;

  typedef struct packed {
    logic inte;
    logic lgc;
    logic shift;
    logic ld;
    logic st;
    logic br;
  } ctrl_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  // One-hot class decode; illegal classes yield an all-zero bundle.
  function automatic ctrl_t decode_ctrl(input logic [2:0] cls);
    ctrl_t c;
    c = '0;
    case (cls)
      CLS_INTE:  c.inte  = 1'b1;
      CLS_LOGIC: c.lgc   = 1'b1;
      CLS_SHIFT: c.shift = 1'b1;
      CLS_LD:    c.ld    = 1'b1;
      CLS_ST:    c.st    = 1'b1;
      CLS_BR:    c.br    = 1'b1;
      default:   c       = '0;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] ext_imm(input logic [2:0] cls,
                                              input logic [IW-1:0] imm);
    logic [XLEN-1:0] v;
    case (cls)
      CLS_LOGIC: v = {{(XLEN-IW){1'b0}}, imm};
      CLS_SHIFT: v = {{(XLEN-5){1'b0}}, imm[4:0]};
      default:   v = {{(XLEN-IW){imm[IW-1]}}, imm};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/regfile.sv
// 2-read/1-write register file with asynchronous read; r0 is hard zero.
module regfile
  import venus_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = (raddr0 == '0) ? '0 : mem[raddr0];
  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];

endmodule

// File: rtl/decode.sv
// Issue/decode stage: decodes class/immediate/destination, reads operands with
// write-back bypass, inserts load-use bubbles and registers the bundle to execute.
module decode
  import venus_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic            inst_valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] rd_value_o,
  output logic [XLEN-1:0] rs_value_o,
  output logic [XLEN-1:0] imm_value_o,
  output logic [AW-1:0]   rd_addr_o,
  output logic            immf_o,
  output logic            ctrl_inte_o,
  output logic            ctrl_logic_o,
  output logic            ctrl_shift_o,
  output logic            ctrl_ld_o,
  output logic            ctrl_st_o,
  output logic            ctrl_br_o,
  output logic [1:0]      subop_o
);

  inst_t           inst;
  ctrl_t           ctrl_d;
  ctrl_t           ctrl_q;
  state_e          state;
  state_e          state_nx;
  logic [XLEN-1:0] rd_rf;
  logic [XLEN-1:0] rs_rf;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] rs_val;
  logic            reads_last;
  logic            hazard;
  logic            accept;

  assign inst   = inst_t'(inst_i);
  assign ctrl_d = decode_ctrl(inst.cls);

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en_i),
    .waddr  (wb_addr_i),
    .wdata  (wb_data_i),
    .raddr0 (inst.rd),
    .raddr1 (inst.rs),
    .rdata0 (rd_rf),
    .rdata1 (rs_rf)
  );

  // Same-cycle write-back forwarding; r0 never forwards.
  assign rd_val = (wb_en_i && (wb_addr_i == inst.rd) && (inst.rd != '0)) ? wb_data_i : rd_rf;
  assign rs_val = (wb_en_i && (wb_addr_i == inst.rs) && (inst.rs != '0)) ? wb_data_i : rs_rf;

  // A held bundle still counts as last issued; bubbles/flushes clear valid_o.
  assign reads_last = (inst.rd == rd_addr_o) || (!inst.immf && (inst.rs == rd_addr_o));
  assign hazard     = (state == ST_RUN) && inst_valid_i && valid_o && ctrl_q.ld && reads_last;
  assign accept     = inst_valid_i && !stall_i && !hazard && !flush_i;
  assign stall_o    = stall_i || hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush_i) begin
      state_nx = ST_RUN;
    end else if (!stall_i) begin
      case (state)
        ST_RUN:    if (hazard) state_nx = ST_BUBBLE;
        ST_BUBBLE: state_nx = ST_RUN;
        default:   state_nx = ST_RUN;
      endcase
    end
  end

  // Output bundle: flush kills, stall holds, otherwise issue or bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o     <= 1'b0;
      ctrl_q      <= '0;
      rd_value_o  <= '0;
      rs_value_o  <= '0;
      imm_value_o <= '0;
      rd_addr_o   <= '0;
      immf_o      <= 1'b0;
      subop_o     <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      ctrl_q  <= '0;
    end else if (!stall_i) begin
      if (accept) begin
        valid_o     <= |ctrl_d;
        ctrl_q      <= ctrl_d;
        rd_value_o  <= rd_val;
        rs_value_o  <= rs_val;
        imm_value_o <= ext_imm(inst.cls, inst.imm);
        rd_addr_o   <= inst.rd;
        immf_o      <= inst.immf;
        subop_o     <= inst.subop;
      end else begin
        valid_o <= 1'b0;
        ctrl_q  <= '0;
      end
    end
  end

  assign ctrl_inte_o  = ctrl_q.inte;
  assign ctrl_logic_o = ctrl_q.lgc;
  assign ctrl_shift_o = ctrl_q.shift;
  assign ctrl_ld_o    = ctrl_q.ld;
  assign ctrl_st_o    = ctrl_q.st;
  assign ctrl_br_o    = ctrl_q.br;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode: decode classes, immediates, bypass,
// load-use bubble, stall/flush and asynchronous reset.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        stall_i;
  logic        flush_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] rd_value_o;
  logic [31:0] rs_value_o;
  logic [31:0] imm_value_o;
  logic [4:0]  rd_addr_o;
  logic        immf_o;
  logic        ctrl_inte_o;
  logic        ctrl_logic_o;
  logic        ctrl_shift_o;
  logic        ctrl_ld_o;
  logic        ctrl_st_o;
  logic        ctrl_br_o;
  logic [1:0]  subop_o;

  int checks = 0;
  int errors = 0;

  decode dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_valid_i (inst_valid_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .wb_en_i      (wb_en_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .stall_o      (stall_o),
    .valid_o      (valid_o),
    .rd_value_o   (rd_value_o),
    .rs_value_o   (rs_value_o),
    .imm_value_o  (imm_value_o),
    .rd_addr_o    (rd_addr_o),
    .immf_o       (immf_o),
    .ctrl_inte_o  (ctrl_inte_o),
    .ctrl_logic_o (ctrl_logic_o),
    .ctrl_shift_o (ctrl_shift_o),
    .ctrl_ld_o    (ctrl_ld_o),
    .ctrl_st_o    (ctrl_st_o),
    .ctrl_br_o    (ctrl_br_o),
    .subop_o      (subop_o)
  );

  always #5 clk = ~clk;

  logic [5:0] ctrl_all;
  assign ctrl_all = {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] c, input logic f, input logic [1:0] so,
                                     input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [15:0] imm);
    return {c, f, so, rd, rs, imm};
  endfunction

  task automatic issue(input logic [31:0] w);
    inst_i       = w;
    inst_valid_i = 1'b1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en_i   = en;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  initial begin
    rst = 1'b0; inst_i = '0; inst_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_rdval", rd_value_o, 32'h0);
    chk("rst_imm", imm_value_o, 32'h0);
    chk("rst_ctrl", 32'(ctrl_all), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    rst = 1'b1;

    // write-back r3, then decode reads it from the array
    wb(1'b1, 5'd3, 32'h1234);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(mk(3'd0, 1'b1, 2'd2, 5'd3, 5'd0, 16'hFFFF));
    tick();
    chk("wb_valid", 32'(valid_o), 32'h1);
    chk("wb_rdval", rd_value_o, 32'h1234);
    chk("inte_imm", imm_value_o, 32'hFFFFFFFF);
    chk("inte_ctrl", 32'(ctrl_all), 32'h20);
    chk("inte_subop", 32'(subop_o), 32'h2);
    chk("inte_rdaddr", 32'(rd_addr_o), 32'h3);

    issue(mk(3'd1, 1'b1, 2'd0, 5'd1, 5'd0, 16'h8001));
    tick();
    chk("logic_imm", imm_value_o, 32'h00008001);
    chk("logic_ctrl", 32'(ctrl_all), 32'h10);
    issue(mk(3'd2, 1'b1, 2'd1, 5'd2, 5'd0, 16'h0027));
    tick();
    chk("shift_imm", imm_value_o, 32'h00000007);
    chk("shift_ctrl", 32'(ctrl_all), 32'h08);
    chk("shift_valid", 32'(valid_o), 32'h1);

    // load-use on rd, with a simultaneous write-back of the hazard register
    issue(mk(3'd3, 1'b1, 2'd0, 5'd4, 5'd0, 16'h0000));
    tick();
    chk("ld_ctrl", 32'(ctrl_all), 32'h04);
    issue(mk(3'd0, 1'b1, 2'd0, 5'd4, 5'd0, 16'h0001));
    wb(1'b1, 5'd4, 32'h77);
    #1 chk("lu_stall", 32'(stall_o), 32'h1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("lu_bubble_valid", 32'(valid_o), 32'h0);
    chk("lu_bubble_ctrl", 32'(ctrl_all), 32'h0);
    #1 chk("lu_bubble_stall", 32'(stall_o), 32'h0);
    tick();
    chk("lu_issue_valid", 32'(valid_o), 32'h1);
    chk("lu_issue_ctrl", 32'(ctrl_all), 32'h20);
    chk("lu_issue_rdval", rd_value_o, 32'h77);

    // rs matches the load but immf=1: no bubble
    issue(mk(3'd3, 1'b1, 2'd0, 5'd4, 5'd0, 16'h0000));
    tick();
    issue(mk(3'd0, 1'b1, 2'd0, 5'd5, 5'd4, 16'h0000));
    #1 chk("nolu_stall", 32'(stall_o), 32'h0);
    tick();
    chk("nolu_valid", 32'(valid_o), 32'h1);
    chk("nolu_rdaddr", 32'(rd_addr_o), 32'h5);

    // downstream stall holds the bundle for three cycles
    issue(mk(3'd0, 1'b1, 2'd0, 5'd3, 5'd0, 16'h0042));
    tick();
    chk("pre_stall_imm", imm_value_o, 32'h42);
    stall_i = 1'b1;
    issue(mk(3'd1, 1'b1, 2'd0, 5'd9, 5'd0, 16'h0005));
    #1 chk("stall_o_follow", 32'(stall_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(valid_o), 32'h1);
      chk("stall_imm", imm_value_o, 32'h42);
      chk("stall_rdaddr", 32'(rd_addr_o), 32'h3);
      chk("stall_ctrl", 32'(ctrl_all), 32'h20);
    end
    flush_i = 1'b1;
    tick();
    chk("flush_stall_valid", 32'(valid_o), 32'h0);
    chk("flush_stall_ctrl", 32'(ctrl_all), 32'h0);
    flush_i = 1'b0; stall_i = 1'b0; inst_valid_i = 1'b0;
    tick();
    chk("idle_valid", 32'(valid_o), 32'h0);

    // r0 stays zero with same-cycle write attempt and afterwards
    wb(1'b1, 5'd0, 32'hDEAD);
    issue(mk(3'd0, 1'b0, 2'd0, 5'd0, 5'd0, 16'h0000));
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("r0_byp_rd", rd_value_o, 32'h0);
    chk("r0_byp_rs", rs_value_o, 32'h0);
    tick();
    chk("r0_arr_rd", rd_value_o, 32'h0);

    // same-cycle bypass on rs, then array read
    wb(1'b1, 5'd7, 32'h55);
    issue(mk(3'd0, 1'b0, 2'd0, 5'd1, 5'd7, 16'h0000));
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("byp_rs", rs_value_o, 32'h55);
    tick();
    chk("arr_rs", rs_value_o, 32'h55);

    // illegal class consumed as invalid
    issue(mk(3'd6, 1'b0, 2'd0, 5'd1, 5'd1, 16'h0000));
    tick();
    chk("ill_valid", 32'(valid_o), 32'h0);
    chk("ill_ctrl", 32'(ctrl_all), 32'h0);
    issue(mk(3'd4, 1'b1, 2'd3, 5'd2, 5'd0, 16'h7FFF));
    tick();
    chk("st_ctrl", 32'(ctrl_all), 32'h02);
    chk("st_imm", imm_value_o, 32'h00007FFF);
    issue(mk(3'd5, 1'b1, 2'd0, 5'd0, 5'd0, 16'h8000));
    tick();
    chk("br_ctrl", 32'(ctrl_all), 32'h01);
    chk("br_imm", imm_value_o, 32'hFFFF8000);

    // flush while in BUBBLE: back to RUN, flushed slot is not a load
    issue(mk(3'd3, 1'b1, 2'd0, 5'd6, 5'd0, 16'h0000));
    tick();
    issue(mk(3'd0, 1'b1, 2'd0, 5'd6, 5'd0, 16'h0000));
    #1 chk("fb_stall", 32'(stall_o), 32'h1);
    tick();
    chk("fb_bubble", 32'(valid_o), 32'h0);
    flush_i = 1'b1;
    tick();
    chk("fb_flush_valid", 32'(valid_o), 32'h0);
    flush_i = 1'b0;
    #1 chk("fb_after_stall", 32'(stall_o), 32'h0);
    tick();
    chk("fb_reissue_valid", 32'(valid_o), 32'h1);
    chk("fb_reissue_rd", 32'(rd_addr_o), 32'h6);

    // async reset in the middle of a stall clears outputs and registers
    inst_valid_i = 1'b0;
    wb(1'b1, 5'd5, 32'hABC);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(mk(3'd0, 1'b1, 2'd0, 5'd5, 5'd0, 16'h0003));
    tick();
    chk("r5_pre", rd_value_o, 32'hABC);
    stall_i = 1'b1;
    tick();
    chk("r5_held", 32'(valid_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_rdval", rd_value_o, 32'h0);
    chk("arst_imm", imm_value_o, 32'h0);
    chk("arst_ctrl", 32'(ctrl_all), 32'h0);
    #1 rst = 1'b1;
    stall_i = 1'b0;
    tick();
    chk("r5_post_valid", 32'(valid_o), 32'h1);
    chk("r5_post", rd_value_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

- Issue/decode stage of the venus pipeline; drives the operand and control bundle consumed by `execute`.
- Accepts a 32-bit instruction from fetch and decodes class, immediate and destination.
- Reads both operands from an internal 32×32 register file with a write-back bypass, and registers the result toward execute.
- Inserts a one-cycle bubble on load-use hazards, and honours downstream stall and branch flush.

## Interface
Parameters:
- NREG, 32, number of architectural registers (addresses 5 bits)
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- inst_i  in  32  instruction: [31:29] class, [28] immf, [27:26] subop, [25:21] rd, [20:16] rs, [15:0] imm16
- inst_valid_i  in  1  inst_i valid this cycle
- stall_i  in  1  downstream stall; hold all outputs
- flush_i  in  1  branch redirect; kill in-flight and current instruction
- wb_en_i / wb_addr_i / wb_data_i  in  1/5/32  register write-back port
- stall_o  out  1  tells fetch to hold inst_i
- valid_o  out  1  output bundle valid
- rd_value_o, rs_value_o, imm_value_o  out  32 each  operands
- rd_addr_o  out  5  destination register
- immf_o, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o  out  1 each
- subop_o  out  2  operation within class

## Operation
Class decode from inst_i[31:29]:
- 000 inte, 001 logic, 010 shift, 011 ld, 100 st, 101 br.
- Exactly one ctrl_*_o is high per valid instruction.
- Classes 110 and 111 are illegal: the instruction is consumed, and valid_o=0 with all ctrl low.

Immediate:
- logic: zero-extend imm16.
- shift: {27'b0, imm16[4:0]}.
- All other classes: sign-extend imm16.

Register file:
- Register 0 reads as 0 and writes to it are ignored.
- Both rd and rs are read every cycle.
- Bypass: if wb_en_i and wb_addr_i equals the read address (≠0), the read returns wb_data_i.

Hazard FSM (states RUN, BUBBLE):
- Hazard condition, evaluated in RUN: the last issued instruction (valid_o=1) is ld, and the current valid instruction reads its destination. Every instruction reads rd; it reads rs only when immf=0.
- On hazard: go to BUBBLE. stall_o=1, and valid_o=0 next cycle.
- BUBBLE → RUN unconditionally after one cycle, unless stall_i is high, in which case BUBBLE holds.
- Accept condition: inst_valid_i & ~stall_i & ~hazard & ~flush_i.

Stall and flush:
- stall_o = stall_i | hazard.
- stall_i high: all registered outputs and FSM state hold.
- flush_i has priority over stall_i: next cycle valid_o=0, all ctrl low, FSM=RUN.

Reset:
- FSM=RUN.
- All outputs 0 (valid_o=0, all values 0).
- All registers cleared to 0.

## Timing
Latency:
- One cycle from accept to valid_o with the bundle.
- Throughput 1 instruction/cycle with no hazard.
- Write-back written at cycle N is visible to a decode read in cycle N through the bypass, and from the array at N+1.

Combinational vs registered:
- stall_o is combinational from stall_i, inst_i and the last-issued load state.
- All other outputs are registered.

Boundary cases:
- Simultaneous write-back and hazard: the bubble is still inserted.
- Flush during BUBBLE: return to RUN, valid_o=0.
- Async reset mid-stall: outputs clear immediately, regardless of stall_i.
- A bubble or flushed slot does not count as a load for hazard detection in the following cycle.

## Structure
Shared package `venus_pkg`:
- Class codes (CLS_INTE..CLS_BR).
- Instruction field bit positions.
- XLEN and NREG constants.
- FSM state enum.

Sub-module `regfile`:
- 2-read/1-write, asynchronous read, async-active-low clear.
- The bypass lives in decode, not in regfile.

## Test plan
- Reset: assert rst=0 mid-stream → valid_o=0, all outputs 0, r5 reads 0 afterward.
- Write-back then decode: wb r3=0x1234 at cycle 0; cycle 1 issue inte immf=1 rd=3 imm=0xFFFF → rd_value_o=0x1234, imm_value_o=0xFFFFFFFF, ctrl_inte_o=1.
- Logic immediate: logic immf=1 imm=0x8001 → imm_value_o=0x00008001. Shift imm=0x0027 → imm_value_o=0x00000007.
- Load-use: ld rd=4 followed by inte rd=4 → one cycle with stall_o=1 and valid_o=0, then inte issues. With rs=4 and immf=1 instead, no bubble.
- Stall and flush: hold stall_i=1 for 3 cycles → outputs unchanged. Assert flush_i together with stall_i → next cycle valid_o=0.
- r0 and bypass: wb to r0=0xDEAD → reads of r0 return 0. Same-cycle wb r7=0x55 with rs=7 → rs_value_o=0x55.
